// File: rtl/g_filter_pkg.sv
// Shared types and limits for the G-output glitch filter.
package g_filter_pkg;

  // Filter FSM: STABLE while s2 agrees with g_out, CHECK while a new level is being qualified.
  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } filt_state_t;

  // Legal range of STABLE_CYCLES.
  localparam int STABLE_CYCLES_MIN = 2;
  localparam int STABLE_CYCLES_MAX = 255;

  // Width of the run counter: enough to hold STABLE_CYCLES-1, never narrower than 1 bit.
  function automatic int run_width(input int stable_cycles);
    return (stable_cycles <= 2) ? 1 : $clog2(stable_cycles);
  endfunction

endpackage

// File: rtl/g_glitch_filter_sync2.sv
// Two-flop synchroniser bringing the raw gate-network output into the clk domain.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] stage_reg;

  // Stage 0 captures the asynchronous input, stage 1 gives it a cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= 2'b00;
    end else begin
      stage_reg <= {stage_reg[0], d};
    end
  end

  assign q = stage_reg[1];

endmodule

// File: rtl/g_glitch_filter.sv
// Glitch filter for G: synchronises the raw level, requires STABLE_CYCLES
// consecutive samples of a new level before accepting it, pulses on accepted
// edges and counts accepted edges and rejected excursions.
module g_glitch_filter
  import g_filter_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             g_in,
  input  logic             clear,
  output logic             g_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam int RUN_W = run_width(STABLE_CYCLES);
  // Run value seen on the cycle that completes qualification.
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);

  logic             s2;
  filt_state_t      state_reg;
  logic [RUN_W-1:0] run_reg;
  logic             g_out_reg;
  logic             rise_reg;
  logic             fall_reg;
  logic [CNT_W-1:0] glitch_cnt_reg;
  logic [CNT_W-1:0] edge_cnt_reg;
  logic             reject_now;
  logic             accept_now;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (g_in),
    .q     (s2)
  );

  // A candidate dies when the sampled level falls back to g_out; it is accepted
  // when it has now been seen for the full STABLE_CYCLES samples.
  assign reject_now = (state_reg == CHECK) && (s2 == g_out_reg);
  assign accept_now = (state_reg == CHECK) && (s2 != g_out_reg) && (run_reg == RUN_LAST);

  // Qualification FSM with registered level and edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= STABLE;
      run_reg   <= '0;
      g_out_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      case (state_reg)
        STABLE: begin
          if (s2 != g_out_reg) begin
            state_reg <= CHECK;
            run_reg   <= RUN_W'(1);
          end
        end
        CHECK: begin
          if (s2 == g_out_reg) begin
            state_reg <= STABLE;
            run_reg   <= '0;
          end else if (run_reg == RUN_LAST) begin
            g_out_reg <= s2;
            rise_reg  <= s2;
            fall_reg  <= ~s2;
            run_reg   <= '0;
            state_reg <= STABLE;
          end else begin
            run_reg <= run_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= STABLE;
          run_reg   <= '0;
        end
      endcase
    end
  end

  // Rejected-excursion counter: saturates at all-ones, clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt_reg <= '0;
    end else if (clear) begin
      glitch_cnt_reg <= '0;
    end else if (reject_now && (glitch_cnt_reg != {CNT_W{1'b1}})) begin
      glitch_cnt_reg <= glitch_cnt_reg + 1'b1;
    end
  end

  // Accepted-edge counter: wraps, clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_reg <= '0;
    end else if (clear) begin
      edge_cnt_reg <= '0;
    end else if (accept_now) begin
      edge_cnt_reg <= edge_cnt_reg + 1'b1;
    end
  end

  assign g_out      = g_out_reg;
  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;
  assign glitch_cnt = glitch_cnt_reg;
  assign edge_cnt   = edge_cnt_reg;

endmodule

// File: tb/tb_g_glitch_filter.sv
// Bench for g_glitch_filter: a default instance and a CNT_W=2 instance share
// stimulus; both are compared every cycle against a behavioural model, plus
// directed checks for the latency, hazard, reset, clear and counter limits.
module tb_g_glitch_filter;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       g_in;
  logic       clear;
  logic       g_out, rise_pulse, fall_pulse;
  logic [7:0] glitch_cnt, edge_cnt;
  logic       g_out_s, rise_s, fall_s;
  logic [1:0] glitch_s, edge_s;

  int n_checks = 0;
  int n_fail   = 0;

  g_glitch_filter #(.STABLE_CYCLES(SC), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .g_in       (g_in),
    .clear      (clear),
    .g_out      (g_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .glitch_cnt (glitch_cnt),
    .edge_cnt   (edge_cnt)
  );

  g_glitch_filter #(.STABLE_CYCLES(SC), .CNT_W(2)) dut_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .g_in       (g_in),
    .clear      (clear),
    .g_out      (g_out_s),
    .rise_pulse (rise_s),
    .fall_pulse (fall_s),
    .glitch_cnt (glitch_s),
    .edge_cnt   (edge_s)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: the filter sees g_in two edges late; it counts how many
  // consecutive samples have disagreed with the accepted level. Reaching SC
  // accepts the new level; agreeing again after a nonzero count is a glitch.
  int m_d1 = 0, m_d2 = 0, m_seen = 0;
  int m_level = 0, m_diff = 0, m_rise = 0, m_fall = 0;
  int m_glitch = 0, m_edges = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d1 = 0; m_d2 = 0; m_level = 0; m_diff = 0;
      m_rise = 0; m_fall = 0; m_glitch = 0; m_edges = 0;
    end else begin
      m_seen = m_d2;
      m_d2   = m_d1;
      m_d1   = int'(g_in);
      m_rise = 0;
      m_fall = 0;
      if (m_seen != m_level) begin
        m_diff = m_diff + 1;
        if (m_diff == SC) begin
          m_level = m_seen;
          if (m_seen == 1) m_rise = 1; else m_fall = 1;
          m_edges = m_edges + 1;
          m_diff  = 0;
        end
      end else begin
        if (m_diff > 0) m_glitch = m_glitch + 1;
        m_diff = 0;
      end
      if (clear) begin
        m_glitch = 0;
        m_edges  = 0;
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  bit model_chk_en = 1'b0;
  int n_rise_seen = 0, n_fall_seen = 0;

  always @(negedge clk) begin
    if (model_chk_en) begin
      check_eq("g_out",       g_out,      m_level);
      check_eq("rise_pulse",  rise_pulse, m_rise);
      check_eq("fall_pulse",  fall_pulse, m_fall);
      check_eq("glitch_cnt",  glitch_cnt, (m_glitch > 255) ? 255 : m_glitch);
      check_eq("edge_cnt",    edge_cnt,   m_edges % 256);
      check_eq("glitch_cnt2", glitch_s,   (m_glitch > 3) ? 3 : m_glitch);
      check_eq("edge_cnt2",   edge_s,     m_edges % 4);
      check_eq("pulse_excl",  rise_pulse & fall_pulse, 0);
      if (rise_pulse) n_rise_seen++;
      if (fall_pulse) n_fall_seen++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int f0, r0, hold;

  initial begin
    rst_n = 1'b0;
    g_in  = 1'b0;
    clear = 1'b0;
    cycles(3);
    check_eq("rst_g_out",  g_out, 0);
    check_eq("rst_glitch", glitch_cnt, 0);
    check_eq("rst_edge",   edge_cnt, 0);
    check_eq("rst_pulses", rise_pulse | fall_pulse, 0);
    rst_n = 1'b1;
    model_chk_en = 1'b1;
    cycles(3);
    $display("tb: reset released g_out=%0d", g_out);

    // 1: accept a rising level at edge SC+2
    g_in = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      if (e == 5) check_eq("t1_g_out_e5", g_out, 0);
      if (e == 6) begin
        check_eq("t1_g_out_e6", g_out, 1);
        check_eq("t1_rise_e6",  rise_pulse, 1);
        check_eq("t1_edge_cnt", edge_cnt, 1);
        check_eq("t1_glitch",   glitch_cnt, 0);
      end
      if (e == 7) check_eq("t1_rise_e7", rise_pulse, 0);
    end
    $display("tb: t1 rise accepted edge_cnt=%0d", edge_cnt);

    // 2: static-1 hazard, G low for two cycles
    r0 = n_rise_seen; f0 = n_fall_seen;
    g_in = 1'b0;
    cycles(2);
    g_in = 1'b1;
    cycles(10);
    check_eq("t2_g_out",  g_out, 1);
    check_eq("t2_glitch", glitch_cnt, 1);
    check_eq("t2_pulses", (n_rise_seen - r0) + (n_fall_seen - f0), 0);
    $display("tb: t2 hazard rejected glitch_cnt=%0d", glitch_cnt);

    // 6: low for 3 samples (rejected), then low for exactly 4 (accepted)
    g_in = 1'b0;
    cycles(3);
    g_in = 1'b1;
    cycles(10);
    check_eq("t6_glitch_a", glitch_cnt, 2);
    check_eq("t6_g_out_a",  g_out, 1);
    f0 = n_fall_seen;
    g_in = 1'b0;
    cycles(4);
    g_in = 1'b1;
    cycles(12);
    check_eq("t6_falls",    n_fall_seen - f0, 1);
    check_eq("t6_glitch_b", glitch_cnt, 2);
    check_eq("t6_edges",    edge_cnt, 3);
    $display("tb: t6 short/long lows glitch_cnt=%0d edge_cnt=%0d", glitch_cnt, edge_cnt);

    // 5: clear on the very edge that rejects a 1-cycle excursion
    g_in = 1'b0;
    cycles(1);
    g_in = 1'b1;
    cycles(2);
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    check_eq("t5_glitch", glitch_cnt, 0);
    check_eq("t5_edge",   edge_cnt, 0);
    cycles(6);
    check_eq("t5_glitch_after", glitch_cnt, 0);
    $display("tb: t5 clear beat increment glitch_cnt=%0d", glitch_cnt);

    // 4: asynchronous reset while qualifying a fall with run=2
    g_in = 1'b0;
    cycles(1);
    g_in = 1'b1;
    cycles(8);
    check_eq("t4_pre_glitch", glitch_cnt, 1);
    g_in = 1'b0;
    cycles(4);
    #1;
    rst_n = 1'b0;
    g_in  = 1'b1;
    #1;
    check_eq("t4_rst_g_out",  g_out, 0);
    check_eq("t4_rst_glitch", glitch_cnt, 0);
    check_eq("t4_rst_edge",   edge_cnt, 0);
    check_eq("t4_rst_pulse",  rise_pulse | fall_pulse, 0);
    cycles(2);
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (e == 5) check_eq("t4_rise_e5", rise_pulse, 0);
      if (e == 6) check_eq("t4_rise_e6", rise_pulse, 1);
    end
    check_eq("t4_glitch_after", glitch_cnt, 0);
    $display("tb: t4 reset mid-check g_out=%0d", g_out);

    // 3: narrow-counter saturation and wrap
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    for (int k = 0; k < 5; k++) begin
      g_in = 1'b0;
      cycles(1);
      g_in = 1'b1;
      cycles(8);
    end
    check_eq("t3_glitch_sat", glitch_s, 3);
    check_eq("t3_glitch_8",   glitch_cnt, 5);
    for (int k = 0; k < 6; k++) begin
      g_in = ~g_in;
      cycles(8);
    end
    check_eq("t3_edge_wrap", edge_s, 2);
    check_eq("t3_edge_8",    edge_cnt, 6);
    $display("tb: t3 narrow counters glitch=%0d edge=%0d", glitch_s, edge_s);

    // Randomised runs of 1..7 cycles with occasional clears, checked by the model.
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (hold == 0) begin
        g_in = ~g_in;
        hold = $urandom_range(1, 7);
      end
      hold--;
      clear = ($urandom_range(0, 31) == 0);
    end
    clear = 1'b0;
    cycles(10);
    $display("tb: random phase done edge_cnt=%0d glitch_cnt=%0d", edge_cnt, glitch_cnt);

    model_chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
